// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if
//   Bundles the two buses of the ROM stream reader:
//     - ROM read side: RomReadEnable_o, RomAddress_o (reader -> ROM),
//       RomData_i (ROM -> reader).
//     - Stream side: Data_o, Valid_o, Last_o (reader -> consumer),
//       Ready_i (consumer -> reader).
//   Stream handshake: a word transfers on a rising edge where Valid_o and
//   Ready_i are both 1. While Valid_o=1 and Ready_i=0, Data_o, Valid_o and
//   Last_o hold. Valid_o never waits on Ready_i. Last_o is meaningful only
//   with Valid_o.
//   Modports: master = the reader, slave = the ROM plus the consumer.
interface rom_stream_reader_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
);
  logic                     RomReadEnable_o;
  logic [ADDRESS_WIDTH-1:0] RomAddress_o;
  logic [DATA_WIDTH-1:0]    RomData_i;
  logic [DATA_WIDTH-1:0]    Data_o;
  logic                     Valid_o;
  logic                     Ready_i;
  logic                     Last_o;

  modport master (
    output RomReadEnable_o, RomAddress_o, Data_o, Valid_o, Last_o,
    input  RomData_i, Ready_i
  );

  modport slave (
    input  RomReadEnable_o, RomAddress_o, Data_o, Valid_o, Last_o,
    output RomData_i, Ready_i
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Reads a burst of consecutive words from a synchronous ROM and streams
//   them out on a valid/ready interface, flagging the final word with Last_o.
//   ROM contract: the ROM samples enable/address at edge N and presents the
//   data at edge N; this block captures the word at edge N+1.
// Ports:
//   Clock, Reset            : rising-edge clock, synchronous active-high reset
//   Start_i                 : 1-cycle burst request, honoured only in IDLE
//   StartAddress_i          : first ROM address of the burst
//   Length_i                : words in burst (1..2^ADDRESS_WIDTH), 0 = no-op
//   Busy_o                  : burst in progress
//   Done_o                  : 1-cycle pulse after the final word transfers
//   State_o                 : FSM state (0 IDLE, 1 RUN, 2 DONE) for debug
//   bus                     : ROM read bus and output stream (master side)
module rom_stream_reader #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start_i,
  input  logic [ADDRESS_WIDTH-1:0] StartAddress_i,
  input  logic [ADDRESS_WIDTH:0]   Length_i,
  output logic                     Busy_o,
  output logic                     Done_o,
  output logic [1:0]               State_o,
  rom_stream_reader_if.master      bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state;
  logic                     rd_en_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic [ADDRESS_WIDTH:0]   issue_left;
  logic [ADDRESS_WIDTH:0]   words_left;
  // Set the cycle after a read strobe: the ROM word is on RomData_i now and
  // is written into the buffer at the coming edge.
  logic                     capture_pending;

  logic [DATA_WIDTH-1:0]    fifo [4];
  logic [1:0]               wr_ptr;
  logic [1:0]               rd_ptr;
  logic [2:0]               occupancy;

  logic                     start_ok;
  logic                     push;
  logic                     pop;
  logic [2:0]               in_flight;
  logic                     can_issue;

  assign start_ok = (state == ST_IDLE) && Start_i && (Length_i != '0);
  assign push     = capture_pending;
  assign pop      = bus.Valid_o && bus.Ready_i;

  // Every word already buffered or still on its way from the ROM holds a
  // buffer slot. A pop this cycle frees one slot at the same edge, which
  // keeps one word per clock flowing with an always-ready consumer.
  assign in_flight = occupancy + {2'b00, rd_en_q} + {2'b00, capture_pending};
  assign can_issue = (state == ST_RUN) && (issue_left != '0) &&
                     ({1'b0, in_flight} < (4'd4 + {3'b000, pop}));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= ST_IDLE;
      Busy_o          <= 1'b0;
      Done_o          <= 1'b0;
      rd_en_q         <= 1'b0;
      addr_q          <= '0;
      next_addr       <= '0;
      issue_left      <= '0;
      words_left      <= '0;
      capture_pending <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occupancy       <= '0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      // Read issue: the first read goes out on the start edge itself.
      if (start_ok) begin
        rd_en_q    <= 1'b1;
        addr_q     <= StartAddress_i;
        next_addr  <= StartAddress_i + 1'b1;
        issue_left <= Length_i - 1'b1;
      end else if (can_issue) begin
        rd_en_q    <= 1'b1;
        addr_q     <= next_addr;
        next_addr  <= next_addr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end else begin
        rd_en_q    <= 1'b0;
      end

      capture_pending <= rd_en_q;

      if (push) begin
        fifo[wr_ptr] <= bus.RomData_i;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occupancy <= occupancy + {2'b00, push} - {2'b00, pop};

      // Words not yet handed to the consumer; the head is the final word
      // when exactly one remains.
      if (start_ok) words_left <= Length_i;
      else if (pop) words_left <= words_left - 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state  <= ST_RUN;
            Busy_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pop && bus.Last_o) begin
            state  <= ST_DONE;
            Busy_o <= 1'b0;
            Done_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          Done_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          Busy_o <= 1'b0;
          Done_o <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RomReadEnable_o = rd_en_q;
  assign bus.RomAddress_o    = addr_q;
  assign bus.Data_o          = fifo[rd_ptr];
  assign bus.Valid_o         = (occupancy != '0);
  assign bus.Last_o          = bus.Valid_o &&
                               (words_left == (ADDRESS_WIDTH + 1)'(1));
  assign State_o             = state;

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
//   Bench for rom_stream_reader. A synchronous ROM model answers reads with
//   {4'hA, addr}. A negedge monitor holds the reference model: an expected
//   word queue filled when a burst is accepted, plus simple busy/done flags
//   derived from the burst rules. Directed tests in the main block cover
//   reset, latency, wrap, backpressure, ignored starts and mid-burst reset.
module tb_rom_stream_reader;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk;
  logic          Reset;
  logic          Start_i;
  logic [AW-1:0] StartAddress_i;
  logic [AW:0]   Length_i;
  logic          Busy_o;
  logic          Done_o;
  logic [1:0]    State_o;

  rom_stream_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) rif ();

  rom_stream_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clock          (clk),
    .Reset          (Reset),
    .Start_i        (Start_i),
    .StartAddress_i (StartAddress_i),
    .Length_i       (Length_i),
    .Busy_o         (Busy_o),
    .Done_o         (Done_o),
    .State_o        (State_o),
    .bus            (rif)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- ROM model ----------------
  always @(posedge clk) begin
    if (rif.RomReadEnable_o === 1'b1) rif.RomData_i <= {4'hA, rif.RomAddress_o};
  end

  // ---------------- consumer ready ----------------
  // 0: held low, 1: held high, 2: random
  int ready_mode = 1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rif.Ready_i = 1'b0;
      1:       rif.Ready_i = 1'b1;
      default: rif.Ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- reference model / monitor ----------------
  logic [DW:0]   exp_q[$];     // {last, data}
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [AW-1:0] m_next_addr = '0;
  int            m_issue_left = 0;
  int            outstanding = 0;
  int            m_xfers = 0;
  int            m_issues = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (Reset) begin
      exp_q.delete();
      m_busy       = 1'b0;
      m_done       = 1'b0;
      m_issue_left = 0;
      outstanding  = 0;
      prev_stall   = 1'b0;
    end else begin
      logic       xfer;
      logic       ended;
      logic [DW:0] exp_w;
      xfer  = rif.Valid_o && rif.Ready_i;
      ended = 1'b0;

      check("busy", Busy_o, m_busy);
      check("done", Done_o, m_done);
      if (!rif.Valid_o) check("last_without_valid", rif.Last_o, 0);
      if (prev_stall) begin
        check("stall_valid_hold", rif.Valid_o, 1);
        check("stall_data_hold", rif.Data_o, prev_data);
      end

      if (rif.RomReadEnable_o) begin
        m_issues++;
        check("issue_within_burst", m_issue_left != 0, 1);
        check("issue_addr", rif.RomAddress_o, m_next_addr);
        m_next_addr = m_next_addr + 1'b1;
        if (m_issue_left != 0) m_issue_left--;
      end

      outstanding = outstanding + int'(rif.RomReadEnable_o) - int'(xfer);
      check("outstanding_le4", outstanding <= 4, 1);

      if (xfer) begin
        m_xfers++;
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("word", {rif.Last_o, rif.Data_o}, exp_w);
          ended = exp_w[DW];
        end
      end

      prev_stall = rif.Valid_o && !rif.Ready_i;
      prev_data  = rif.Data_o;

      // Burst-level rules for the next cycle.
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_busy) begin
        if (Start_i && Length_i != 0) begin
          for (int i = 0; i < int'(Length_i); i++) begin
            logic [AW-1:0] a;
            a = StartAddress_i + AW'(i);
            exp_q.push_back({(i == int'(Length_i) - 1), 4'hA, a});
          end
          m_busy       = 1'b1;
          m_next_addr  = StartAddress_i;
          m_issue_left = int'(Length_i);
        end
      end else if (ended) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Main-block time base: 2 time units after a rising edge.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic start_burst(input logic [AW-1:0] sa, input logic [AW:0] len);
    Start_i        = 1'b1;
    StartAddress_i = sa;
    Length_i       = len;
    cycle();
    Start_i        = 1'b0;
    StartAddress_i = AW'($urandom);
    Length_i       = (AW+1)'($urandom);
  endtask

  // Called in cycle 1 after the start edge; returns during the Done cycle.
  task automatic wait_done(input int timeout, output int fr, output int fv,
                           output int dc);
    fr = -1; fv = -1; dc = -1;
    for (int c = 1; c <= timeout; c++) begin
      if (rif.RomReadEnable_o && fr < 0) fr = c;
      if (rif.Valid_o && fv < 0) fv = c;
      if (Done_o) begin
        dc = c;
        break;
      end
      cycle();
    end
    check("done_seen", dc > 0, 1);
  endtask

  task automatic run_burst(input logic [AW-1:0] sa, input logic [AW:0] len,
                           input int timeout, output int fr, output int fv,
                           output int dc);
    start_burst(sa, len);
    wait_done(timeout, fr, fv, dc);
    cycle();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  Busy_o, 0);
    check({tag, "_done"},  Done_o, 0);
    check({tag, "_rden"},  rif.RomReadEnable_o, 0);
    check({tag, "_addr"},  rif.RomAddress_o, 0);
    check({tag, "_data"},  rif.Data_o, 0);
    check({tag, "_valid"}, rif.Valid_o, 0);
    check({tag, "_last"},  rif.Last_o, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int fr, fv, dc, base, cnt;
    Reset          = 1'b1;
    Start_i        = 1'b0;
    StartAddress_i = '0;
    Length_i       = '0;
    ready_mode     = 1;
    repeat (3) cycle();
    check_outputs_zero("reset");
    Reset = 1'b0;
    cycle();

    // Full burst from 0, always ready: latency and throughput.
    run_burst(4'h0, 5'd16, 40, fr, fv, dc);
    check("full_first_read_cycle", fr, 1);
    check("full_first_valid_cycle", fv, 3);
    check("full_done_cycle", dc, 19);

    // Address wrap.
    run_burst(4'hE, 5'd4, 40, fr, fv, dc);
    check("wrap_done_cycle", dc, 7);

    // Backpressure: consumer stalled for 10 cycles.
    ready_mode = 0;
    cycle();
    base = m_issues;
    start_burst(4'h0, 5'd8);
    repeat (10) cycle();
    check("bp_issue_count", m_issues - base, 4);
    check("bp_valid", rif.Valid_o, 1);
    check("bp_head", rif.Data_o, 8'hA0);
    ready_mode = 1;
    wait_done(80, fr, fv, dc);
    cycle();

    // Random ready, full burst then random bursts.
    ready_mode = 2;
    run_burst(4'h0, 5'd16, 400, fr, fv, dc);
    for (int n = 0; n < 5; n++) begin
      run_burst(AW'($urandom), (AW+1)'($urandom_range(1, 16)), 400, fr, fv, dc);
    end

    // Start during RUN and during DONE are ignored.
    ready_mode = 1;
    start_burst(4'h5, 5'd6);
    cycle();
    start_burst(4'h9, 5'd3);
    wait_done(40, fr, fv, dc);
    start_burst(4'h7, 5'd2);
    check("ignored_start_in_done_busy", Busy_o, 0);
    repeat (4) cycle();
    check("ignored_start_idle_busy", Busy_o, 0);
    check("ignored_start_idle_valid", rif.Valid_o, 0);

    // Length 0 is a no-op.
    cnt = m_issues;
    start_burst(4'h3, 5'd0);
    repeat (6) cycle();
    check("noop_busy", Busy_o, 0);
    check("noop_no_reads", m_issues - cnt, 0);

    // Reset mid-burst, then a short burst.
    ready_mode = 1;
    base = m_xfers;
    start_burst(4'h0, 5'd16);
    for (int c = 0; c < 40; c++) begin
      if (m_xfers - base >= 5) break;
      cycle();
    end
    check("midreset_words_before", m_xfers - base >= 5, 1);
    Reset = 1'b1;
    cycle();
    check_outputs_zero("midreset");
    Reset = 1'b0;
    cycle();
    base = m_xfers;
    run_burst(4'h3, 5'd2, 40, fr, fv, dc);
    check("post_reset_word_count", m_xfers - base, 2);

    repeat (4) cycle();
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
